recepcao_serial: RTL and testbench

Serial receiver for one 3x3 cube face: deserializes 8N1 UART bytes from the host, validates each as a 3-bit color code and emits one write strobe per sticker with row/column address. It is the receiving end of the face-transfer link whose transmitting end is `transmissao_serial`. It sits in front of the face memory that the solver datapath reads.

---
 rtl/rubiks_pkg.sv | 29 ++
 rtl/rx_serial_8N1.sv | 121 ++++++++++++
 rtl/recepcao_serial.sv | 120 ++++++++++++
 tb/tb_recepcao_serial.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rubiks_pkg.sv
// rubiks_pkg: types and constants shared by the cube-face serial link.
// Holds the control FSM state encoding, the 3-bit color code type,
// the number of valid colors and the face dimensions.
package rubiks_pkg;

  localparam int FACE_DIM = 3;
  localparam int N_CORES  = 6;

  // Highest row/column index on a face
  localparam logic [1:0] ULTIMO_IDX = 2'(FACE_DIM - 1);

  typedef logic [2:0] cor_t;

  typedef enum logic [3:0] {
    INICIAL  = 4'd0,
    ESPERA   = 4'd1,
    VALIDA   = 4'd2,
    ARMAZENA = 4'd3,
    PROXIMO  = 4'd4,
    FINAL    = 4'd5
  } estado_t;

  // A received byte is a color only if the upper bits are clear
  // and the code is below the number of colors in use.
  function automatic logic cor_valida(input logic [7:0] b, input int n_cores);
    return (b[7:3] == 5'd0) && (int'(b[2:0]) < n_cores);
  endfunction

endpackage

// File: rtl/rx_serial_8N1.sv
// rx_serial_8N1: UART byte receiver, LSB first, one stop bit.
// 2-FF input synchronizer, baud timer, bit counter and shift register.
// Emits a one-cycle pronto with dado and erro_frame one cycle after the
// stop bit sample. Build option RECEPCAO_PARIDADE_EN switches the frame
// to 8E1; a parity mismatch is reported through erro_frame.
module rx_serial_8N1 #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [7:0] dado,
  output logic       pronto,
  output logic       erro_frame
);

  localparam int TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] MEIO_BIT = TW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] FIM_BIT  = TW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    RX_OCIOSO   = 3'd0,
    RX_INICIO   = 3'd1,
    RX_DADOS    = 3'd2,
    RX_PARIDADE = 3'd3,
    RX_PARADA   = 3'd4,
    RX_PRONTO   = 3'd5
  } rx_estado_t;

  rx_estado_t    estado_reg, estado_next;
  logic [1:0]    sync_reg;
  logic          rx_prev_reg;
  logic          rx_sinc;
  logic [TW-1:0] timer_reg, timer_next;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    dado_reg;
  logic          erro_frame_reg;
  logic          par_err_reg;
  logic          tick_meio, tick_bit;

  assign rx_sinc   = sync_reg[1];
  assign tick_meio = (timer_reg == MEIO_BIT);
  assign tick_bit  = (timer_reg == FIM_BIT);

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_reg    <= 2'b11;
      rx_prev_reg <= 1'b1;
    end else begin
      sync_reg    <= {sync_reg[0], entrada_serial};
      rx_prev_reg <= rx_sinc;
    end
  end

  // Receiver state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_reg <= RX_OCIOSO;
    else        estado_reg <= estado_next;
  end

  // Receiver next-state: start edge, mid-start check, bits, stop, pulse
  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      RX_OCIOSO:   if (rx_prev_reg && !rx_sinc) estado_next = RX_INICIO;
      RX_INICIO:   if (tick_meio) estado_next = rx_sinc ? RX_OCIOSO : RX_DADOS;
      RX_DADOS:    if (tick_bit && (bit_cnt_reg == 3'd7)) begin
`ifdef RECEPCAO_PARIDADE_EN
                     estado_next = RX_PARIDADE;
`else
                     estado_next = RX_PARADA;
`endif
                   end
      RX_PARIDADE: if (tick_bit) estado_next = RX_PARADA;
      RX_PARADA:   if (tick_bit) estado_next = RX_PRONTO;
      RX_PRONTO:   estado_next = RX_OCIOSO;
      default:     estado_next = RX_OCIOSO;
    endcase
  end

  // Receiver outputs and baud timer: the timer restarts on every state
  // change and every full bit period, so samples land mid-bit
  always_comb begin
    pronto     = (estado_reg == RX_PRONTO);
    dado       = dado_reg;
    erro_frame = erro_frame_reg;
    timer_next = timer_reg + 1'b1;
    if ((estado_next != estado_reg) || tick_bit) timer_next = '0;
  end

  // Datapath: timer, bit counter, shifter and frame checks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_reg      <= '0;
      bit_cnt_reg    <= 3'd0;
      dado_reg       <= 8'd0;
      erro_frame_reg <= 1'b0;
      par_err_reg    <= 1'b0;
    end else begin
      timer_reg <= timer_next;
      case (estado_reg)
        RX_INICIO: begin
          bit_cnt_reg <= 3'd0;
          par_err_reg <= 1'b0;
        end
        RX_DADOS: if (tick_bit) begin
          dado_reg    <= {rx_sinc, dado_reg[7:1]};
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
`ifdef RECEPCAO_PARIDADE_EN
        // Even parity: data bits plus parity bit must hold an even count of ones
        RX_PARIDADE: if (tick_bit) par_err_reg <= (^dado_reg) ^ rx_sinc;
`endif
        RX_PARADA: if (tick_bit) erro_frame_reg <= !rx_sinc || par_err_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/recepcao_serial.sv
// recepcao_serial: receives one 3x3 cube face over UART, validates each
// byte as a color code and issues one write strobe per sticker with its
// row/column address. Build option RECEPCAO_PARIDADE_EN selects 8E1
// framing in the byte receiver (default 8N1).
module recepcao_serial #(
  parameter int BAUD_DIV = 434,
  parameter int N_CORES  = rubiks_pkg::N_CORES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       entrada_serial,
  output logic [2:0] dados_pixel,
  output logic [1:0] addr_linha,
  output logic [1:0] addr_coluna,
  output logic       escreve,
  output logic       fim,
  output logic       erro,
  output logic [3:0] db_estado
);

  import rubiks_pkg::*;

  estado_t    estado_reg, estado_next;
  logic [7:0] byte_reg;
  logic       frame_err_reg;
  logic       erro_reg;
  logic [1:0] linha_reg, coluna_reg;
  logic [7:0] rx_dado;
  logic       rx_pronto;
  logic       rx_erro_frame;
  logic       byte_ok;
  logic       ultima_pos;

  rx_serial_8N1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_rx (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .dado          (rx_dado),
    .pronto        (rx_pronto),
    .erro_frame    (rx_erro_frame)
  );

  assign byte_ok    = !frame_err_reg && cor_valida(byte_reg, N_CORES);
  assign ultima_pos = (linha_reg == ULTIMO_IDX) && (coluna_reg == ULTIMO_IDX);

  // Control FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado_reg <= INICIAL;
    else        estado_reg <= estado_next;
  end

  // Control FSM next-state
  always_comb begin
    estado_next = estado_reg;
    case (estado_reg)
      INICIAL:  if (iniciar) estado_next = ESPERA;
      ESPERA:   if (rx_pronto) estado_next = VALIDA;
      VALIDA:   estado_next = byte_ok ? ARMAZENA : ESPERA;
      ARMAZENA: estado_next = PROXIMO;
      PROXIMO:  estado_next = ultima_pos ? FINAL : ESPERA;
      FINAL:    estado_next = INICIAL;
      default:  estado_next = INICIAL;
    endcase
  end

  // Control FSM outputs
  always_comb begin
    escreve     = (estado_reg == ARMAZENA);
    fim         = (estado_reg == FINAL);
    dados_pixel = byte_reg[2:0];
    addr_linha  = linha_reg;
    addr_coluna = coluna_reg;
    erro        = erro_reg;
    db_estado   = estado_reg;
  end

  // Byte capture, sticky error and row/column address counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_reg      <= 8'd0;
      frame_err_reg <= 1'b0;
      erro_reg      <= 1'b0;
      linha_reg     <= 2'd0;
      coluna_reg    <= 2'd0;
    end else begin
      case (estado_reg)
        INICIAL: begin
          linha_reg  <= 2'd0;
          coluna_reg <= 2'd0;
          if (iniciar) erro_reg <= 1'b0;
        end
        ESPERA: if (rx_pronto) begin
          byte_reg      <= rx_dado;
          frame_err_reg <= rx_erro_frame;
        end
        VALIDA: if (!byte_ok) erro_reg <= 1'b1;
        PROXIMO: begin
          if (ultima_pos) begin
            linha_reg  <= 2'd0;
            coluna_reg <= 2'd0;
          end else if (coluna_reg == ULTIMO_IDX) begin
            coluna_reg <= 2'd0;
            linha_reg  <= linha_reg + 2'd1;
          end else begin
            coluna_reg <= coluna_reg + 2'd1;
          end
        end
        FINAL: begin
          linha_reg  <= 2'd0;
          coluna_reg <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_recepcao_serial.sv
// tb_recepcao_serial: directed bench for recepcao_serial. Expected
// sticker writes are queued as bytes are sent and popped by a monitor
// on every escreve strobe. Uses a shortened bit period to keep runs short.
module tb_recepcao_serial;

  localparam int BAUD = 120;

  typedef struct packed {
    logic [1:0] l;
    logic [1:0] c;
    logic [2:0] p;
  } wr_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic       entrada_serial = 1'b1;
  logic [2:0] dados_pixel;
  logic [1:0] addr_linha, addr_coluna;
  logic       escreve, fim, erro;
  logic [3:0] db_estado;

  int  n_cmp = 0;
  int  n_err = 0;
  int  fim_cnt = 0;
  int  desde_escreve = 1000;
  wr_t exp_q[$];

  recepcao_serial #(.BAUD_DIV(BAUD), .N_CORES(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .entrada_serial(entrada_serial),
    .dados_pixel   (dados_pixel),
    .addr_linha    (addr_linha),
    .addr_coluna   (addr_coluna),
    .escreve       (escreve),
    .fim           (fim),
    .erro          (erro),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [2:0] p);
    wr_t e;
    e.l = 2'(k / 3);
    e.c = 2'(k % 3);
    e.p = p;
    exp_q.push_back(e);
  endtask

  // One UART frame, LSB first; stop bit level selectable
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    entrada_serial = 1'b0;
    repeat (BAUD) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      entrada_serial = b[i];
      repeat (BAUD) @(negedge clock);
    end
`ifdef RECEPCAO_PARIDADE_EN
    entrada_serial = ^b;
    repeat (BAUD) @(negedge clock);
`endif
    entrada_serial = stop_bit;
    repeat (BAUD) @(negedge clock);
    entrada_serial = 1'b1;
  endtask

`ifdef RECEPCAO_PARIDADE_EN
  task automatic send_byte_bad_par(input logic [7:0] b);
    entrada_serial = 1'b0;
    repeat (BAUD) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      entrada_serial = b[i];
      repeat (BAUD) @(negedge clock);
    end
    entrada_serial = ~(^b);
    repeat (BAUD) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (BAUD) @(negedge clock);
  endtask
`endif

  task automatic pulse_iniciar();
    @(negedge clock) iniciar = 1'b1;
    @(negedge clock) iniciar = 1'b0;
  endtask

  task automatic wait_fim(input int alvo);
    int n = 0;
    while (fim_cnt < alvo && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("fim_count", fim_cnt, alvo);
  endtask

  task automatic check_reset_outputs();
    check("rst_escreve", escreve, 0);
    check("rst_fim", fim, 0);
    check("rst_erro", erro, 0);
    check("rst_dados_pixel", dados_pixel, 0);
    check("rst_addr_linha", addr_linha, 0);
    check("rst_addr_coluna", addr_coluna, 0);
    check("rst_db_estado", db_estado, 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest queued write;
  // fim must follow the last write by exactly 2 cycles
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      if (escreve === 1'b1) begin
        desde_escreve = 0;
        n_cmp++;
        assert (exp_q.size() > 0) else begin
          n_err++;
          $error("FAIL escreve_unexpected: observed write (%0d,%0d)=%0d expected no write",
                 addr_linha, addr_coluna, dados_pixel);
        end
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("escreve_addr_pixel", {addr_linha, addr_coluna, dados_pixel}, e);
        end
      end else if (desde_escreve < 1000) begin
        desde_escreve++;
      end
      if (fim === 1'b1) begin
        fim_cnt++;
        check("fim_latency", desde_escreve, 2);
        check("fim_queue_empty", exp_q.size(), 0);
      end
    end
  end

  initial begin
    logic [7:0] face1 [9];
    logic [7:0] face2 [7];
    face1 = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h01, 8'h02};
    face2 = '{8'h03, 8'h04, 8'h05, 8'h00, 8'h01, 8'h02, 8'h03};

    // Reset state
    #1 reset = 1'b0;
    repeat (4) @(negedge clock);
    check_reset_outputs();
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Face 1: nine valid stickers, no errors
    pulse_iniciar();
    check("iniciar_espera", db_estado, 1);
    for (int k = 0; k < 9; k++) begin
      push_exp(k, face1[k][2:0]);
      send_byte(face1[k], 1'b1);
    end
    wait_fim(1);
    check("face1_erro", erro, 0);
    repeat (3) @(negedge clock);
    check("face1_inicial", db_estado, 0);

    // Face 2: invalid code 0x07 after two stickers
    pulse_iniciar();
    push_exp(0, 3'd0);
    send_byte(8'h00, 1'b1);
    push_exp(1, 3'd1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h07, 1'b1);
    check("code7_erro", erro, 1);
    check("code7_estado", db_estado, 1);
    check("code7_coluna", addr_coluna, 2);
    for (int k = 0; k < 7; k++) begin
      push_exp(k + 2, face2[k][2:0]);
      send_byte(face2[k], 1'b1);
    end
    wait_fim(2);
    check("face2_erro_sticky", erro, 1);

    // Face 3: framing error, glitch, then reset mid-face
    pulse_iniciar();
    check("iniciar_clears_erro", erro, 0);
    push_exp(0, 3'd4);
    send_byte(8'h04, 1'b1);
    send_byte(8'h03, 1'b0);
    check("frame_erro", erro, 1);
    check("frame_linha", addr_linha, 0);
    check("frame_coluna", addr_coluna, 1);
    check("frame_queue", exp_q.size(), 0);

    entrada_serial = 1'b0;
    repeat (50) @(negedge clock);
    entrada_serial = 1'b1;
    repeat (300) @(negedge clock);
    check("glitch_estado", db_estado, 1);
    check("glitch_coluna", addr_coluna, 1);

    push_exp(1, 3'd5);
    send_byte(8'h05, 1'b1);
    push_exp(2, 3'd0);
    send_byte(8'h00, 1'b1);
    push_exp(3, 3'd1);
    send_byte(8'h01, 1'b1);
    check("four_writes_queue", exp_q.size(), 0);
    check("four_writes_linha", addr_linha, 1);
    check("four_writes_coluna", addr_coluna, 1);

    entrada_serial = 1'b0;
    repeat (2 * BAUD) @(negedge clock);
    reset = 1'b0;
    entrada_serial = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Face 4 after reset starts at (0,0)
    pulse_iniciar();
    for (int k = 0; k < 9; k++) begin
      push_exp(k, face1[k][2:0]);
      send_byte(face1[k], 1'b1);
    end
    wait_fim(3);
    check("face4_erro", erro, 0);

`ifdef RECEPCAO_PARIDADE_EN
    // Parity: wrong parity rejected, correct parity written
    repeat (3) @(negedge clock);
    pulse_iniciar();
    send_byte_bad_par(8'h01);
    check("par_bad_erro", erro, 1);
    check("par_bad_estado", db_estado, 1);
    check("par_bad_queue", exp_q.size(), 0);
    push_exp(0, 3'd1);
    send_byte(8'h01, 1'b1);
    check("par_good_queue", exp_q.size(), 0);
    check("par_good_coluna", addr_coluna, 1);
`endif

    repeat (5) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
